// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the systolic array result path.
//   drain_state_t       - drain FSM states (IDLE, WAIT, CAPTURE, STREAM)
//   ACC_W               - accumulator lane width
//   SAT_MAX / SAT_MIN   - signed 16-bit clamp bounds for optional saturation
package systolic_pkg;

    localparam int ACC_W = 32;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 32'sh0000_7FFF;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -32'sh0000_8000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        STREAM  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/systolic_drain_sat.sv
// systolic_drain_sat: combinational signed clamp of a 32-bit accumulator
// into the signed 16-bit range.
//   din  - 32-bit signed accumulator value
//   dout - clamped 16-bit signed value (caller sign-extends)
module systolic_drain_sat
    import systolic_pkg::*;
(
    input  logic [ACC_W-1:0] din,
    output logic [15:0]      dout
);

    always_comb begin
        dout = din[15:0];
        if ($signed(din) > SAT_MAX) begin
            dout = SAT_MAX[15:0];
        end else if ($signed(din) < SAT_MIN) begin
            dout = SAT_MIN[15:0];
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: result-side reader for an M x N systolic array.
// Waits k_len+M+N-1 cycles after start, snapshots all accumulators while
// pulsing acc_clear, then streams one row per valid/ready beat.
//   clk, rst         - clock, asynchronous active-high reset
//   start, k_len     - pass launch pulse and inner dimension K
//   c_in             - flattened accumulators, element (i,j) at [(i*N+j)*32 +: 32]
//   acc_clear        - one-cycle clear strobe to all PEs
//   busy             - high whenever not IDLE
//   out_valid/ready  - row handshake; out_data/out_row/out_last describe the beat
//   overrun          - sticky, start seen while busy
// Optional macro SYSTOLIC_DRAIN_SAT_EN clamps each captured element to
// signed 16 bits, sign-extended into its 32-bit lane.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int M   = 4,
    parameter int N   = 4,
    parameter int K_W = 8,
    localparam int RW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic [M*N*ACC_W-1:0]   c_in,
    output logic                   acc_clear,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*ACC_W-1:0]     out_data,
    output logic [RW-1:0]          out_row,
    output logic                   out_last,
    output logic                   overrun
);

    localparam int CW = K_W + 1 + $clog2(M + N);

    drain_state_t         state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [RW-1:0]        row_nx;
    logic [M*N*ACC_W-1:0] snap, cap_val;
    logic                 hs;

    // out_valid is a registered copy of (state == STREAM), so this handshake
    // never feeds back combinationally into out_valid.
    assign hs = out_valid & out_ready;

    genvar e;
    generate
        for (e = 0; e < M*N; e++) begin : g_cap
`ifdef SYSTOLIC_DRAIN_SAT_EN
            logic [15:0] sat16;
            systolic_drain_sat u_sat (
                .din  (c_in[e*ACC_W +: ACC_W]),
                .dout (sat16)
            );
            assign cap_val[e*ACC_W +: ACC_W] = {{(ACC_W-16){sat16[15]}}, sat16};
`else
            assign cap_val[e*ACC_W +: ACC_W] = c_in[e*ACC_W +: ACC_W];
`endif
        end
    endgenerate

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        row_nx   = out_row;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nx   = CW'(k_len) + CW'(M + N - 1);
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                row_nx   = '0;
                state_nx = STREAM;
            end
            STREAM: begin
                if (hs) begin
                    if (out_row == RW'(M - 1)) begin
                        state_nx = IDLE;
                    end else begin
                        row_nx = out_row + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs are registered from the next-state decode so they line
    // up with the state they describe without any output-side logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_row   <= '0;
            snap      <= '0;
            acc_clear <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            out_row   <= row_nx;
            acc_clear <= (state_nx == CAPTURE);
            busy      <= (state_nx != IDLE);
            out_valid <= (state_nx == STREAM);
            out_last  <= (state_nx == STREAM) && (row_nx == RW'(M - 1));
            // Snapshot is taken on the same edge the PEs see acc_clear, so it
            // holds the pre-clear values.
            if (state == CAPTURE) begin
                snap <= cap_val;
            end
            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    assign out_data = snap[int'(out_row)*N*ACC_W +: N*ACC_W];

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;

    localparam int M   = 4;
    localparam int N   = 4;
    localparam int K_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [K_W-1:0]     k_len;
    logic [M*N*32-1:0]  c_in;
    logic               acc_clear;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [N*32-1:0]    out_data;
    logic [1:0]         out_row;
    logic               out_last;
    logic               overrun;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    systolic_drain #(.M(M), .N(N), .K_W(K_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .c_in      (c_in),
        .acc_clear (acc_clear),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .overrun   (overrun)
    );

    function automatic logic [N*32-1:0] exp_row(int r);
        logic [N*32-1:0] v;
        for (int j = 0; j < N; j++) v[j*32 +: 32] = 32'(16*r + j);
        return v;
    endfunction

    task automatic load_pattern();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                c_in[(i*N+j)*32 +: 32] = 32'(16*i + j);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b0; c_in = '0;
        #1;
        tests++;
        if ({acc_clear, busy, out_valid, out_last, overrun} !== 5'b0)
            begin fails++; $display("FAIL reset_flags got=%b want=00000", {acc_clear, busy, out_valid, out_last, overrun}); end
        tests++;
        if (out_data !== '0 || out_row !== 2'd0)
            begin fails++; $display("FAIL reset_data got data=%h row=%0d want 0", out_data, out_row); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency();
        load_pattern(); out_ready = 1'b1; k_len = 8'd4;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            start = (c == 0);
            if (c == 13) c_in = '0;
            tests++;
            if (acc_clear !== (c == 12))
                begin fails++; $display("FAIL lat_clear c=%0d got=%b want=%b", c, acc_clear, (c == 12)); end
            tests++;
            if (out_valid !== (c >= 13 && c <= 16))
                begin fails++; $display("FAIL lat_valid c=%0d got=%b", c, out_valid); end
            tests++;
            if (busy !== (c >= 1 && c <= 16))
                begin fails++; $display("FAIL lat_busy c=%0d got=%b", c, busy); end
            if (c >= 13 && c <= 16) begin
                tests++;
                if (out_row !== 2'(c-13) || out_data !== exp_row(c-13) || out_last !== (c == 16))
                    begin fails++; $display("FAIL lat_beat c=%0d got row=%0d last=%b data=%h want row=%0d data=%h", c, out_row, out_last, out_data, c-13, exp_row(c-13)); end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_backpressure();
        logic pat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int hs = 0;
        load_pattern(); k_len = 8'd4; out_ready = 1'b0;
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            start = (c == 0);
            out_ready = (c >= 13) ? ((c - 13 < 8) ? pat[c-13] : 1'b1) : 1'b0;
            tests++;
            if (out_valid !== (c >= 13 && hs < 4))
                begin fails++; $display("FAIL bp_valid c=%0d got=%b hs=%0d", c, out_valid, hs); end
            tests++;
            if (busy !== (c >= 1 && c <= 20))
                begin fails++; $display("FAIL bp_busy c=%0d got=%b", c, busy); end
            if (out_valid && hs < 4) begin
                tests++;
                if (out_row !== 2'(hs) || out_data !== exp_row(hs) || out_last !== (hs == 3))
                    begin fails++; $display("FAIL bp_beat c=%0d got row=%0d data=%h want row=%0d data=%h", c, out_row, out_data, hs, exp_row(hs)); end
            end
            if (out_valid && out_ready) hs++;
        end
        tests++;
        if (hs != 4)
            begin fails++; $display("FAIL bp_handshakes got=%0d want=4", hs); end
        start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_overrun();
        load_pattern(); out_ready = 1'b1; k_len = 8'd4;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == 5);
            tests++;
            if (overrun !== (c >= 6))
                begin fails++; $display("FAIL ovr_flag c=%0d got=%b want=%b", c, overrun, (c >= 6)); end
            tests++;
            if (acc_clear !== (c == 12) || out_valid !== (c >= 13 && c <= 16) || busy !== (c >= 1 && c <= 16))
                begin fails++; $display("FAIL ovr_timing c=%0d got clr=%b vld=%b busy=%b", c, acc_clear, out_valid, busy); end
            if (c >= 13 && c <= 16) begin
                tests++;
                if (out_row !== 2'(c-13) || out_data !== exp_row(c-13))
                    begin fails++; $display("FAIL ovr_beat c=%0d got row=%0d data=%h want data=%h", c, out_row, out_data, exp_row(c-13)); end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_klen0();
        load_pattern(); out_ready = 1'b1; k_len = 8'd0;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            start = (c == 0);
            tests++;
            if (acc_clear !== (c == 8) || out_valid !== (c >= 9 && c <= 12) || busy !== (c >= 1 && c <= 12))
                begin fails++; $display("FAIL k0_timing c=%0d got clr=%b vld=%b busy=%b", c, acc_clear, out_valid, busy); end
            tests++;
            if (overrun !== 1'b1)
                begin fails++; $display("FAIL k0_overrun_sticky c=%0d got=%b want=1", c, overrun); end
            if (c >= 9 && c <= 12) begin
                tests++;
                if (out_row !== 2'(c-9) || out_data !== exp_row(c-9) || out_last !== (c == 12))
                    begin fails++; $display("FAIL k0_beat c=%0d got row=%0d data=%h want data=%h", c, out_row, out_data, exp_row(c-9)); end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_midstream();
        load_pattern(); k_len = 8'd4;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            start = (c == 0);
            out_ready = (c == 13 || c == 14);
        end
        tests++;
        if (out_valid !== 1'b1 || out_row !== 2'd2)
            begin fails++; $display("FAIL rst_pre got vld=%b row=%0d want 1/2", out_valid, out_row); end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({acc_clear, busy, out_valid, out_last, overrun} !== 5'b0 || out_data !== '0 || out_row !== 2'd0)
            begin fails++; $display("FAIL rst_async got flags=%b data=%h row=%0d want 0", {acc_clear, busy, out_valid, out_last, overrun}, out_data, out_row); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0 || busy !== 1'b0)
                begin fails++; $display("FAIL rst_quiet c=%0d got vld=%b busy=%b want 0", c, out_valid, busy); end
        end
        k_len = 8'd0;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            start = (c == 0);
            if (c == 9) begin
                tests++;
                if (out_valid !== 1'b1 || out_row !== 2'd0 || out_data !== exp_row(0) || overrun !== 1'b0)
                    begin fails++; $display("FAIL rst_restart got vld=%b row=%0d data=%h ovr=%b want 1/0/%h/0", out_valid, out_row, out_data, overrun, exp_row(0)); end
            end
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_saturation();
        logic [N*32-1:0] want0, want1;
        c_in = '0;
        c_in[0*32 +: 32] = 32'h0001_0000;
        c_in[1*32 +: 32] = 32'hFFFE_0000;
        c_in[2*32 +: 32] = 32'h0000_1234;
        c_in[3*32 +: 32] = 32'hFFFF_FFFE;
        c_in[4*32 +: 32] = 32'h8000_0000;
        c_in[5*32 +: 32] = 32'h7FFF_FFFF;
`ifdef SYSTOLIC_DRAIN_SAT_EN
        want0 = {32'hFFFF_FFFE, 32'h0000_1234, 32'hFFFF_8000, 32'h0000_7FFF};
        want1 = {32'h0, 32'h0, 32'h0000_7FFF, 32'hFFFF_8000};
`else
        want0 = {32'hFFFF_FFFE, 32'h0000_1234, 32'hFFFE_0000, 32'h0001_0000};
        want1 = {32'h0, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000};
`endif
        out_ready = 1'b1; k_len = 8'd0;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            start = (c == 0);
            if (c == 9) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== want0)
                    begin fails++; $display("FAIL sat_row0 got vld=%b data=%h want data=%h", out_valid, out_data, want0); end
            end
            if (c == 10) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== want1)
                    begin fails++; $display("FAIL sat_row1 got vld=%b data=%h want data=%h", out_valid, out_data, want1); end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_overrun();
        test_klen0();
        test_reset_midstream();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
